// File: rtl/adder_share_pkg.sv
// Shared types and sizes for the two-requester shared-adder sequencer.
package adder_share_pkg;
    localparam int OPW  = 4;
    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/adder4.sv
// 4-bit unsigned adder with carry out.
module adder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic       CO,
    output logic [3:0] S
);
    assign {CO, S} = {1'b0, A} + {1'b0, B};
endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; a tie goes to the requester not last served.
module rr_arb2
    import adder_share_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic            last,
    output logic [NREQ-1:0] win
);
    // One-hot winner from request vector and last-served index.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
endmodule

// File: rtl/sevenseg.sv
// Hex digit to seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
module sevenseg (
    input  logic [3:0] sum,
    output logic [6:0] display
);
    // Segment lookup.
    always_comb begin
        display = 7'h00;
        case (sum)
            4'h0: display = 7'h3F;
            4'h1: display = 7'h06;
            4'h2: display = 7'h5B;
            4'h3: display = 7'h4F;
            4'h4: display = 7'h66;
            4'h5: display = 7'h6D;
            4'h6: display = 7'h7D;
            4'h7: display = 7'h07;
            4'h8: display = 7'h7F;
            4'h9: display = 7'h6F;
            4'hA: display = 7'h77;
            4'hB: display = 7'h7C;
            4'hC: display = 7'h39;
            4'hD: display = 7'h5E;
            4'hE: display = 7'h79;
            4'hF: display = 7'h71;
            default: display = 7'h00;
        endcase
    end
endmodule

// File: rtl/adder_share_ctrl.sv
// Arbitrates two requesters onto one adder4 through an IDLE/LOAD/EXEC/DONE
// sequence and shows the last completed sum on a seven-segment display.
module adder_share_ctrl
    import adder_share_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] Req,
    input  logic [OPW-1:0]  A0,
    input  logic [OPW-1:0]  B0,
    input  logic [OPW-1:0]  A1,
    input  logic [OPW-1:0]  B1,
    output logic [NREQ-1:0] Grant,
    output logic [NREQ-1:0] Done,
    output logic [OPW-1:0]  Sum,
    output logic            Cout,
    output logic            Busy,
    output logic [6:0]      Display
);
    state_t          state_r, next_state_s;
    logic [NREQ-1:0] grant_r, done_r, win_s;
    logic [OPW-1:0]  opa_r, opb_r, sum_r, disp_r, add_s;
    logic            cout_r, busy_r, last_r, add_co_s;

    rr_arb2 u_arb (
        .req  (Req),
        .last (last_r),
        .win  (win_s)
    );

    adder4 u_add (
        .A  (opa_r),
        .B  (opb_r),
        .CO (add_co_s),
        .S  (add_s)
    );

    sevenseg u_seg (
        .sum     (disp_r),
        .display (Display)
    );

    // Next-state sequencing; Req only matters in IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|Req) begin
                    next_state_s = LOAD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOAD:    next_state_s = EXEC;
            EXEC:    next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant, operands, results and pointer; Done/Busy are registered to track the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r <= 2'b00;
            done_r  <= 2'b00;
            busy_r  <= 1'b0;
            opa_r   <= 4'd0;
            opb_r   <= 4'd0;
            sum_r   <= 4'd0;
            cout_r  <= 1'b0;
            disp_r  <= 4'd0;
            last_r  <= 1'b1;
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= (next_state_s == DONE) ? grant_r : 2'b00;
            case (state_r)
                IDLE: begin
                    if (|Req) begin
                        grant_r <= win_s;
                        opa_r   <= win_s[1] ? A1 : A0;
                        opb_r   <= win_s[1] ? B1 : B0;
                    end
                end
                EXEC: begin
                    sum_r  <= add_s;
                    cout_r <= add_co_s;
                    disp_r <= add_s;
                end
                DONE: begin
                    grant_r <= 2'b00;
                    last_r  <= grant_r[1];
                end
                default: begin
                    grant_r <= grant_r;
                end
            endcase
        end
    end

    assign Grant = grant_r;
    assign Done  = done_r;
    assign Sum   = sum_r;
    assign Cout  = cout_r;
    assign Busy  = busy_r;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench: stimulus queues expected completions, a monitor checks each Done pulse.
module tb_adder_share_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] Req = 2'b00;
    logic [3:0] A0 = 4'd0, B0 = 4'd0, A1 = 4'd0, B1 = 4'd0;
    logic [1:0] Grant, Done;
    logic [3:0] Sum;
    logic       Cout, Busy;
    logic [6:0] Display;

    typedef struct packed {
        logic [1:0] done;
        logic [3:0] sum;
        logic       cout;
        logic [6:0] disp;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    adder_share_ctrl dut (
        .clk(clk), .rst(rst), .Req(Req),
        .A0(A0), .B0(B0), .A1(A1), .B1(B1),
        .Grant(Grant), .Done(Done), .Sum(Sum), .Cout(Cout),
        .Busy(Busy), .Display(Display)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] d, input logic [3:0] s, input logic c, input logic [6:0] p);
        exp_t e;
        e.done = d; e.sum = s; e.cout = c; e.disp = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input logic [1:0] g);
        int t = 0;
        while (Grant !== g && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("grant", {6'd0, Grant}, {6'd0, g});
    endtask

    task automatic wait_idle();
        int t = 0;
        while (Busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("busy_drop", {7'd0, Busy}, 8'd0);
        @(negedge clk);
    endtask

    // Monitor: legality every cycle, and compare each Done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (Grant == 2'b11) begin
                n_err++;
                $display("FAIL grant_onehot: got %b, expected one-hot or zero", Grant);
            end
            if (Done != 2'b00) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got Done=%b Sum=%0d, expected no Done", Done, Sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done",    {6'd0, Done},    {6'd0, e.done});
                    check("sum",     {4'd0, Sum},     {4'd0, e.sum});
                    check("cout",    {7'd0, Cout},    {7'd0, e.cout});
                    check("display", {1'b0, Display}, {1'b0, e.disp});
                end
            end
        end
    end

    initial begin
        // Reset values while reset is held.
        @(negedge clk);
        check("rst_grant", {6'd0, Grant}, 8'd0);
        check("rst_done",  {6'd0, Done},  8'd0);
        check("rst_busy",  {7'd0, Busy},  8'd0);
        check("rst_sum",   {3'd0, Cout, Sum}, 8'd0);
        check("rst_disp",  {1'b0, Display}, 8'h3F);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0 alone: 3+4=7.
        A0 = 4'd3; B0 = 4'd4; Req = 2'b01;
        push(2'b01, 4'd7, 1'b0, 7'h07);
        wait_grant(2'b01);
        check("busy_on", {7'd0, Busy}, 8'd1);
        Req = 2'b00;
        wait_idle();

        // Requester 1 alone: 9+8=17 wraps to 1 with carry.
        A1 = 4'd9; B1 = 4'd8; Req = 2'b10;
        push(2'b10, 4'd1, 1'b1, 7'h06);
        wait_grant(2'b10);
        Req = 2'b00;
        wait_idle();

        // Tie: pointer was set by requester 1, so 0 wins first, then 1.
        A0 = 4'd1; B0 = 4'd1; A1 = 4'd2; B1 = 4'd2; Req = 2'b11;
        push(2'b01, 4'd2, 1'b0, 7'h5B);
        push(2'b10, 4'd4, 1'b0, 7'h66);
        wait_grant(2'b01);
        wait_grant(2'b10);
        Req = 2'b00;
        wait_idle();

        // Operands and Req change after the grant do not disturb the operation.
        A0 = 4'd5; B0 = 4'd5; Req = 2'b01;
        push(2'b01, 4'd10, 1'b0, 7'h77);
        wait_grant(2'b01);
        A0 = 4'd0; Req = 2'b00;
        wait_idle();

        // Long idle: nothing moves, previous result holds.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_busy", {6'd0, Busy, 1'b0} | {6'd0, 1'b0, |Done}, 8'd0);
        end
        check("hold_sum",  {4'd0, Sum}, 8'd10);
        check("hold_disp", {1'b0, Display}, 8'h77);

        // Reset during EXEC aborts with no Done.
        A0 = 4'd3; B0 = 4'd4; Req = 2'b01;
        wait_grant(2'b01);
        Req = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_sum",   {3'd0, Cout, Sum}, 8'd0);
        check("abort_grant", {6'd0, Grant}, 8'd0);
        check("abort_done",  {6'd0, Done},  8'd0);
        check("abort_busy",  {7'd0, Busy},  8'd0);
        check("abort_disp",  {1'b0, Display}, 8'h3F);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_abort_busy", {7'd0, Busy}, 8'd0);
        check("post_abort_sum",  {4'd0, Sum}, 8'd0);

        check("queue_empty", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
